// File: rtl/sm_clkdiv_sched_if.sv
// Control-side bundle for the PIO step scheduler: divider settings and control
// pulses in, per-SM step/force/restart strobes out.
interface sm_clkdiv_sched_if #(
    parameter int NUM_SM = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
);
    logic [NUM_SM-1:0][INT_W-1:0]  clkdiv_int;
    logic [NUM_SM-1:0][FRAC_W-1:0] clkdiv_frac;
    logic [NUM_SM-1:0]             sm_en;
    logic [NUM_SM-1:0]             clkdiv_restart;
    logic [NUM_SM-1:0]             sm_restart;
    logic [NUM_SM-1:0]             instr_flag;
    logic [NUM_SM-1:0]             sm_tick;
    logic [NUM_SM-1:0]             sm_force;
    logic [NUM_SM-1:0]             sm_rst_pulse;
    logic [NUM_SM-1:0]             force_drop;

    modport master (
        output clkdiv_int, clkdiv_frac, sm_en, clkdiv_restart, sm_restart, instr_flag,
        input  sm_tick, sm_force, sm_rst_pulse, force_drop
    );

    modport slave (
        input  clkdiv_int, clkdiv_frac, sm_en, clkdiv_restart, sm_restart, instr_flag,
        output sm_tick, sm_force, sm_rst_pulse, force_drop
    );
endinterface

// File: rtl/sm_clkdiv_sched.sv
// Per-state-machine 16.8 fractional step divider with forced-instruction issue
// and restart strobes; every output is a flop.
module sm_clkdiv_sched #(
    parameter int NUM_SM = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    sm_clkdiv_sched_if.slave   bus
);
    localparam int CNT_W = INT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(1) << INT_W;

    logic [NUM_SM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_SM-1:0][FRAC_W-1:0] acc_q, acc_d;
    logic [NUM_SM-1:0]             pend_q, pend_d;
    logic [NUM_SM-1:0]             tick_q, tick_d;
    logic [NUM_SM-1:0]             force_q, force_d;
    logic [NUM_SM-1:0]             rst_pulse_q, rst_pulse_d;
    logic [NUM_SM-1:0]             drop_q, drop_d;

    logic [NUM_SM-1:0][CNT_W-1:0]  int_eff;
    logic [NUM_SM-1:0][FRAC_W:0]   frac_sum;
    logic [NUM_SM-1:0]             issue;

    // A zero integer divisor stands for the full 2^INT_W period.
    always_comb begin
        int_eff  = '0;
        frac_sum = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            int_eff[i]  = (bus.clkdiv_int[i] == '0) ? CNT_WRAP : {1'b0, bus.clkdiv_int[i]};
            frac_sum[i] = {1'b0, acc_q[i]} + {1'b0, bus.clkdiv_frac[i]};
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        tick_d = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (bus.clkdiv_restart[i]) begin
                cnt_d[i] = CNT_ONE;
                acc_d[i] = '0;
            end else if (bus.sm_en[i]) begin
                if (cnt_q[i] == CNT_ONE) begin
                    tick_d[i] = 1'b1;
                    acc_d[i]  = frac_sum[i][FRAC_W-1:0];
                    cnt_d[i]  = int_eff[i] + CNT_W'(frac_sum[i][FRAC_W]);
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    // A stalled SM takes its forced instruction straight away; a running one
    // waits for its next step. A restart edge suppresses issue entirely.
    always_comb begin
        issue       = '0;
        force_d     = '0;
        drop_d      = '0;
        pend_d      = pend_q;
        rst_pulse_d = bus.sm_restart;
        for (int i = 0; i < NUM_SM; i++) begin
            issue[i]   = pend_q[i] & (tick_d[i] | ~bus.sm_en[i]) & ~bus.sm_restart[i];
            force_d[i] = issue[i];
            drop_d[i]  = bus.instr_flag[i] & pend_q[i] & ~issue[i];
            if (bus.sm_restart[i]) begin
                pend_d[i] = bus.instr_flag[i];
            end else begin
                pend_d[i] = bus.instr_flag[i] | (pend_q[i] & ~issue[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= {NUM_SM{CNT_ONE}};
            acc_q       <= '0;
            pend_q      <= '0;
            tick_q      <= '0;
            force_q     <= '0;
            rst_pulse_q <= '0;
            drop_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            force_q     <= force_d;
            rst_pulse_q <= rst_pulse_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.sm_tick      = tick_q;
    assign bus.sm_force     = force_q;
    assign bus.sm_rst_pulse = rst_pulse_q;
    assign bus.force_drop   = drop_q;
endmodule

// File: tb/tb_sm_clkdiv_sched.sv
// Scenario bench for sm_clkdiv_sched: per-feature tasks with inline checks,
// backed by an arithmetic per-SM reference model.
module tb_sm_clkdiv_sched;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sm_clkdiv_sched_if #(.NUM_SM(4), .INT_W(16), .FRAC_W(8)) bus ();

    sm_clkdiv_sched #(.NUM_SM(4), .INT_W(16), .FRAC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining cycles until the next step, fraction carried
    // as an integer remainder of 256, and a pending-force bit per SM.
    int         m_rem  [4] = '{1, 1, 1, 1};
    int         m_acc  [4] = '{0, 0, 0, 0};
    bit         m_pend [4] = '{0, 0, 0, 0};
    logic [3:0] exp_tick  = '0;
    logic [3:0] exp_force = '0;
    logic [3:0] exp_rst   = '0;
    logic [3:0] exp_drop  = '0;

    always @(posedge clk) begin : ref_model
        int         rem  [4];
        int         acc  [4];
        bit         pend [4];
        logic [3:0] nt, nf, nd;
        int         period;
        bit         iss;
        nt = '0;
        nf = '0;
        nd = '0;
        for (int i = 0; i < 4; i++) begin
            rem[i]  = m_rem[i];
            acc[i]  = m_acc[i];
            pend[i] = m_pend[i];
        end
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rem[i]  = 1;
                acc[i]  = 0;
                pend[i] = 0;
            end
            exp_rst <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.clkdiv_restart[i]) begin
                    rem[i] = 1;
                    acc[i] = 0;
                end else if (bus.sm_en[i]) begin
                    if (rem[i] == 1) begin
                        period = (bus.clkdiv_int[i] == 0) ? 65536 : int'(bus.clkdiv_int[i]);
                        rem[i] = period + (acc[i] + int'(bus.clkdiv_frac[i])) / 256;
                        acc[i] = (acc[i] + int'(bus.clkdiv_frac[i])) % 256;
                        nt[i]  = 1'b1;
                    end else begin
                        rem[i] = rem[i] - 1;
                    end
                end
                iss   = pend[i] && (nt[i] || !bus.sm_en[i]) && !bus.sm_restart[i];
                nf[i] = iss;
                nd[i] = bus.instr_flag[i] && pend[i] && !iss;
                if (bus.sm_restart[i]) pend[i] = bus.instr_flag[i];
                else                   pend[i] = bus.instr_flag[i] || (pend[i] && !iss);
            end
            exp_rst <= bus.sm_restart;
        end
        m_rem     <= rem;
        m_acc     <= acc;
        m_pend    <= pend;
        exp_tick  <= nt;
        exp_force <= nf;
        exp_drop  <= nd;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if (bus.sm_tick !== 4'h0) begin errors++; $display("[TB] FAIL reset_tick got %h exp 0", bus.sm_tick); end
        checks++;
        if (bus.sm_force !== 4'h0) begin errors++; $display("[TB] FAIL reset_force got %h exp 0", bus.sm_force); end
        checks++;
        if (bus.sm_rst_pulse !== 4'h0) begin errors++; $display("[TB] FAIL reset_rst_pulse got %h exp 0", bus.sm_rst_pulse); end
        checks++;
        if (bus.force_drop !== 4'h0) begin errors++; $display("[TB] FAIL reset_drop got %h exp 0", bus.force_drop); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.clkdiv_int[0]  = 16'd1;
        bus.clkdiv_frac[0] = 8'd0;
        bus.sm_en[0]       = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++;
            if (bus.sm_tick !== 4'b0001) begin
                errors++; $display("[TB] FAIL b2b_tick cycle %0d got %b exp 0001", c, bus.sm_tick);
            end
            checks++;
            if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
                errors++; $display("[TB] FAIL b2b_model got %h exp %h", {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
            end
        end
        bus.sm_en[0] = 1'b0;
        cyc();
        checks++;
        if (bus.sm_tick !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_disable got %b exp 0000", bus.sm_tick); end
    endtask

    task automatic test_fractional();
        int n_ticks;
        int last;
        int want_gap;
        bus.clkdiv_int[1]     = 16'd2;
        bus.clkdiv_frac[1]    = 8'h80;
        bus.sm_en[1]          = 1'b1;
        bus.clkdiv_restart[1] = 1'b1;
        cyc();
        bus.clkdiv_restart[1] = 1'b0;
        checks++;
        if (bus.sm_tick[1] !== 1'b0) begin errors++; $display("[TB] FAIL frac_restart_quiet got %b exp 0", bus.sm_tick[1]); end
        cyc();
        checks++;
        if (bus.sm_tick[1] !== 1'b1) begin errors++; $display("[TB] FAIL frac_first_tick got %b exp 1", bus.sm_tick[1]); end
        n_ticks = 0;
        last    = 0;
        for (int c = 1; c <= 25; c++) begin
            cyc();
            checks++;
            if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
                errors++; $display("[TB] FAIL frac_model cycle %0d got %h exp %h", c, {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
            end
            if (bus.sm_tick[1] === 1'b1) begin
                n_ticks++;
                want_gap = (n_ticks % 2 == 1) ? 2 : 3;
                checks++;
                if (c - last !== want_gap) begin
                    errors++; $display("[TB] FAIL frac_gap tick %0d got %0d exp %0d", n_ticks, c - last, want_gap);
                end
                last = c;
            end
        end
        checks++;
        if (n_ticks !== 10) begin errors++; $display("[TB] FAIL frac_count got %0d exp 10", n_ticks); end
        bus.sm_en[1] = 1'b0;
        cyc();
    endtask

    task automatic test_phase_align();
        int n_ticks;
        bus.clkdiv_int[0]  = 16'd5;
        bus.clkdiv_frac[0] = 8'h40;
        bus.clkdiv_int[2]  = 16'd5;
        bus.clkdiv_frac[2] = 8'h40;
        bus.sm_en[0] = 1'b1;
        repeat (3) cyc();
        bus.sm_en[2] = 1'b1;
        repeat (7) cyc();
        bus.clkdiv_restart[0] = 1'b1;
        bus.clkdiv_restart[2] = 1'b1;
        cyc();
        bus.clkdiv_restart[0] = 1'b0;
        bus.clkdiv_restart[2] = 1'b0;
        n_ticks = 0;
        for (int c = 1; c <= 60; c++) begin
            cyc();
            checks++;
            if (bus.sm_tick[0] !== bus.sm_tick[2]) begin
                errors++; $display("[TB] FAIL phase_lockstep cycle %0d got sm0=%b sm2=%b exp equal", c, bus.sm_tick[0], bus.sm_tick[2]);
            end
            checks++;
            if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
                errors++; $display("[TB] FAIL phase_model cycle %0d got %h exp %h", c, {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
            end
            if (bus.sm_tick[0] === 1'b1) n_ticks++;
        end
        checks++;
        if (n_ticks !== 12) begin errors++; $display("[TB] FAIL phase_count got %0d exp 12", n_ticks); end
        bus.sm_en[0] = 1'b0;
        bus.sm_en[2] = 1'b0;
        cyc();
    endtask

    task automatic test_force_disabled();
        bus.sm_en[1]      = 1'b0;
        bus.instr_flag[1] = 1'b1;
        cyc();
        bus.instr_flag[1] = 1'b0;
        checks++;
        if (bus.sm_force[1] !== 1'b0) begin errors++; $display("[TB] FAIL fdis_early got %b exp 0", bus.sm_force[1]); end
        cyc();
        checks++;
        if (bus.sm_force[1] !== 1'b1) begin errors++; $display("[TB] FAIL fdis_issue got %b exp 1", bus.sm_force[1]); end
        cyc();
        checks++;
        if (bus.sm_force[1] !== 1'b0) begin errors++; $display("[TB] FAIL fdis_single got %b exp 0", bus.sm_force[1]); end
        checks++;
        if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
            errors++; $display("[TB] FAIL fdis_model got %h exp %h", {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
        end
    endtask

    task automatic test_force_enabled();
        int  w;
        int  n_force;
        bit  first_seen;
        bus.clkdiv_int[1]     = 16'd4;
        bus.clkdiv_frac[1]    = 8'd0;
        bus.sm_en[1]          = 1'b1;
        bus.clkdiv_restart[1] = 1'b1;
        cyc();
        bus.clkdiv_restart[1] = 1'b0;
        w = 0;
        while (bus.sm_tick[1] !== 1'b1 && w < 20) begin cyc(); w++; end
        checks++;
        if (bus.sm_tick[1] !== 1'b1) begin errors++; $display("[TB] FAIL fen_wait_tick got timeout exp tick within 20"); end
        repeat ($urandom_range(0, 2)) cyc();
        bus.instr_flag[1] = 1'b1;
        cyc();
        bus.instr_flag[1] = 1'b0;
        n_force    = 0;
        first_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            checks++;
            if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
                errors++; $display("[TB] FAIL fen_model cycle %0d got %h exp %h", c, {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
            end
            if (bus.sm_force[1] === 1'b1) n_force++;
            if (bus.sm_tick[1] === 1'b1 && !first_seen) begin
                first_seen = 1'b1;
                checks++;
                if (bus.sm_force[1] !== 1'b1) begin errors++; $display("[TB] FAIL fen_with_tick got %b exp 1", bus.sm_force[1]); end
            end
        end
        checks++;
        if (n_force !== 1) begin errors++; $display("[TB] FAIL fen_count got %0d exp 1", n_force); end
    endtask

    task automatic test_force_drop();
        int w;
        int n_force;
        int n_drop;
        w = 0;
        while (bus.sm_tick[1] !== 1'b1 && w < 20) begin cyc(); w++; end
        checks++;
        if (bus.sm_tick[1] !== 1'b1) begin errors++; $display("[TB] FAIL drop_wait_tick got timeout exp tick within 20"); end
        bus.instr_flag[1] = 1'b1;
        cyc();
        n_drop  = (bus.force_drop[1] === 1'b1) ? 1 : 0;
        n_force = (bus.sm_force[1] === 1'b1) ? 1 : 0;
        cyc();
        bus.instr_flag[1] = 1'b0;
        checks++;
        if (bus.force_drop[1] !== 1'b1) begin errors++; $display("[TB] FAIL drop_pulse got %b exp 1", bus.force_drop[1]); end
        for (int c = 0; c < 7; c++) begin
            if (bus.force_drop[1] === 1'b1) n_drop++;
            if (bus.sm_force[1] === 1'b1) begin
                n_force++;
                checks++;
                if (bus.sm_tick[1] !== 1'b1) begin errors++; $display("[TB] FAIL drop_force_align got tick=%b exp 1", bus.sm_tick[1]); end
            end
            cyc();
            checks++;
            if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
                errors++; $display("[TB] FAIL drop_model cycle %0d got %h exp %h", c, {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
            end
        end
        checks++;
        if (n_drop !== 1) begin errors++; $display("[TB] FAIL drop_count got %0d exp 1", n_drop); end
        checks++;
        if (n_force !== 1) begin errors++; $display("[TB] FAIL drop_force_count got %0d exp 1", n_force); end
        bus.sm_en[1] = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_restart_flag();
        int w;
        int n_force;
        bus.clkdiv_int[2]     = 16'd4;
        bus.clkdiv_frac[2]    = 8'd0;
        bus.sm_en[2]          = 1'b1;
        bus.clkdiv_restart[2] = 1'b1;
        cyc();
        bus.clkdiv_restart[2] = 1'b0;
        w = 0;
        while (bus.sm_tick[2] !== 1'b1 && w < 20) begin cyc(); w++; end
        checks++;
        if (bus.sm_tick[2] !== 1'b1) begin errors++; $display("[TB] FAIL rsf_wait_tick got timeout exp tick within 20"); end
        bus.instr_flag[2] = 1'b1;
        cyc();
        bus.sm_restart[2] = 1'b1;
        cyc();
        bus.instr_flag[2] = 1'b0;
        bus.sm_restart[2] = 1'b0;
        checks++;
        if (bus.sm_rst_pulse[2] !== 1'b1) begin errors++; $display("[TB] FAIL rsf_pulse got %b exp 1", bus.sm_rst_pulse[2]); end
        checks++;
        if (bus.sm_force[2] !== 1'b0) begin errors++; $display("[TB] FAIL rsf_no_force got %b exp 0", bus.sm_force[2]); end
        n_force = 0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (c == 0) begin
                checks++;
                if (bus.sm_rst_pulse[2] !== 1'b0) begin errors++; $display("[TB] FAIL rsf_pulse_len got %b exp 0", bus.sm_rst_pulse[2]); end
            end
            checks++;
            if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
                errors++; $display("[TB] FAIL rsf_model cycle %0d got %h exp %h", c, {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
            end
            if (bus.sm_force[2] === 1'b1) begin
                n_force++;
                checks++;
                if (bus.sm_tick[2] !== 1'b1) begin errors++; $display("[TB] FAIL rsf_force_align got tick=%b exp 1", bus.sm_tick[2]); end
            end
        end
        checks++;
        if (n_force !== 1) begin errors++; $display("[TB] FAIL rsf_force_count got %0d exp 1", n_force); end
        bus.sm_en[2] = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.clkdiv_int[0]     = 16'd1;
        bus.clkdiv_frac[0]    = 8'd0;
        bus.clkdiv_int[1]     = 16'd8;
        bus.clkdiv_frac[1]    = 8'd0;
        bus.sm_en[0]          = 1'b1;
        bus.sm_en[1]          = 1'b1;
        bus.clkdiv_restart[0] = 1'b1;
        bus.clkdiv_restart[1] = 1'b1;
        cyc();
        bus.clkdiv_restart[0] = 1'b0;
        bus.clkdiv_restart[1] = 1'b0;
        repeat (2) cyc();
        bus.instr_flag[1] = 1'b1;
        cyc();
        bus.instr_flag[1] = 1'b0;
        rst = 1'b1;
        cyc();
        checks++;
        if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== 16'h0000) begin
            errors++; $display("[TB] FAIL rmid_zero got %h exp 0000", {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop});
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (bus.sm_tick[1:0] !== 2'b11) begin errors++; $display("[TB] FAIL rmid_first_tick got %b exp 11", bus.sm_tick[1:0]); end
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (bus.sm_force !== 4'h0) begin errors++; $display("[TB] FAIL rmid_stale_force cycle %0d got %h exp 0", c, bus.sm_force); end
            checks++;
            if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
                errors++; $display("[TB] FAIL rmid_model cycle %0d got %h exp %h", c, {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
            end
            cyc();
        end
        bus.sm_en[0] = 1'b0;
        bus.sm_en[1] = 1'b0;
        cyc();
    endtask

    task automatic test_zero_divisor();
        int gap;
        bus.clkdiv_int[3]     = 16'd0;
        bus.clkdiv_frac[3]    = 8'd0;
        bus.sm_en[3]          = 1'b1;
        bus.clkdiv_restart[3] = 1'b1;
        cyc();
        bus.clkdiv_restart[3] = 1'b0;
        cyc();
        checks++;
        if (bus.sm_tick[3] !== 1'b1) begin errors++; $display("[TB] FAIL zdiv_first_tick got %b exp 1", bus.sm_tick[3]); end
        gap = 0;
        do begin
            cyc();
            gap++;
        end while (bus.sm_tick[3] !== 1'b1 && gap < 70000);
        checks++;
        if (gap !== 65536) begin errors++; $display("[TB] FAIL zdiv_gap got %0d exp 65536", gap); end
        checks++;
        if ({bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop} !== {exp_tick, exp_force, exp_rst, exp_drop}) begin
            errors++; $display("[TB] FAIL zdiv_model got %h exp %h", {bus.sm_tick, bus.sm_force, bus.sm_rst_pulse, bus.force_drop}, {exp_tick, exp_force, exp_rst, exp_drop});
        end
        bus.sm_en[3] = 1'b0;
        cyc();
    endtask

    initial begin
        rst                = 1'b1;
        bus.clkdiv_int     = '0;
        bus.clkdiv_frac    = '0;
        bus.sm_en          = '0;
        bus.clkdiv_restart = '0;
        bus.sm_restart     = '0;
        bus.instr_flag     = '0;
        test_reset();
        test_back_to_back();
        test_fractional();
        test_phase_align();
        test_force_disabled();
        test_force_enabled();
        test_force_drop();
        test_restart_flag();
        test_reset_mid();
        test_zero_divisor();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
